// File: rtl/stream_upsize_keep.sv
// Narrow-to-wide stream packer: collects T_DATA_RATIO beats into one word with a
// per-lane keep mask, early flush on last, selectable lane order and a registered output.
module stream_upsize_keep #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2,
    parameter int MSB_FIRST    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH-1:0]              s_data_i,
    input  logic                                 s_valid_i,
    input  logic                                 s_last_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] m_data_o,
    output logic [T_DATA_RATIO-1:0]              m_keep_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);

    localparam int W  = T_DATA_WIDTH;
    localparam int R  = T_DATA_RATIO;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(R - 1);

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_lane;
    logic [W*R-1:0] r_acc_data;
    logic [W*R-1:0] w_merge_data;
    logic [W*R-1:0] r_out_data;
    logic [R-1:0]   r_acc_keep;
    logic [R-1:0]   w_merge_keep;
    logic [R-1:0]   r_out_keep;
    logic           r_out_last;
    logic           r_out_valid;
    logic           w_ready;
    logic           w_accept;
    logic           w_complete;

    // Ready is held low during reset and whenever the output word is stalled.
    assign w_ready    = ~rst & (~r_out_valid | m_ready_i);
    assign w_accept   = s_valid_i & w_ready;
    assign w_complete = w_accept & ((r_cnt == LAST_BEAT) | s_last_i);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_lane = LAST_BEAT - r_cnt;
        end else begin : g_lsb_first
            assign w_lane = r_cnt;
        end
    endgenerate

    // Merged view of the accumulator with the beat being accepted this cycle.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            logic w_hit;
            assign w_hit = w_accept & (w_lane == CW'(gi));
            assign w_merge_data[gi*W +: W] = w_hit ? s_data_i : r_acc_data[gi*W +: W];
            assign w_merge_keep[gi]        = w_hit | r_acc_keep[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc_data  <= '0;
            r_acc_keep  <= '0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_out_data <= w_merge_data;
                    r_out_keep <= w_merge_keep;
                    r_out_last <= s_last_i;
                    r_cnt      <= '0;
                    r_acc_data <= '0;
                    r_acc_keep <= '0;
                end else begin
                    r_acc_data <= w_merge_data;
                    r_acc_keep <= w_merge_keep;
                    r_cnt      <= r_cnt + 1'b1;
                end
            end
            // A completing beat can only be accepted when the slot is empty or draining.
            if (w_complete) begin
                r_out_valid <= 1'b1;
            end else if (m_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign s_ready_o = w_ready;
    assign m_data_o  = r_out_data;
    assign m_keep_o  = r_out_keep;
    assign m_last_o  = r_out_last;
    assign m_valid_o = r_out_valid;

endmodule

// File: tb/tb_stream_upsize_keep.sv
// Bench for stream_upsize_keep: LSB-first and MSB-first instances share one stimulus;
// directed steps followed by a random phase scored against a beat-list model.
module tb_stream_upsize_keep;

    localparam int W = 4;
    localparam int R = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           m_ready = 1'b0;

    logic           s_ready_l, s_ready_m;
    logic [W*R-1:0] m_data_l, m_data_m;
    logic [R-1:0]   m_keep_l, m_keep_m;
    logic           m_last_l, m_last_m;
    logic           m_valid_l, m_valid_m;

    int n_chk = 0;
    int n_err = 0;
    int n_words = 0;
    bit en_sb = 1'b0;

    typedef struct {
        logic [W*R-1:0] d_l;
        logic [W*R-1:0] d_m;
        logic [R-1:0]   k_l;
        logic [R-1:0]   k_m;
        logic           last;
    } word_t;

    word_t        exp_q[$];
    logic [W-1:0] cur_beats[$];

    always #5 clk = ~clk;

    stream_upsize_keep #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready_l),
        .m_data_o(m_data_l), .m_keep_o(m_keep_l), .m_last_o(m_last_l),
        .m_valid_o(m_valid_l), .m_ready_i(m_ready)
    );

    stream_upsize_keep #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready_m),
        .m_data_o(m_data_m), .m_keep_o(m_keep_m), .m_last_o(m_last_m),
        .m_valid_o(m_valid_m), .m_ready_i(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    // Scoreboard: inputs are stable at the falling edge, so this sees the handshakes
    // that the next rising edge will perform.
    always @(negedge clk) begin
        if (en_sb) begin
            if (m_valid_l && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", 32'(m_data_l), 32'hFFFF_FFFF);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("sb_data_lsb", 32'(m_data_l), 32'(e.d_l));
                    chk("sb_keep_lsb", 32'(m_keep_l), 32'(e.k_l));
                    chk("sb_data_msb", 32'(m_data_m), 32'(e.d_m));
                    chk("sb_keep_msb", 32'(m_keep_m), 32'(e.k_m));
                    chk("sb_last", 32'(m_last_l), 32'(e.last));
                    chk("sb_valid_msb", 32'(m_valid_m), 32'd1);
                    n_words++;
                end
            end
            if (s_valid && s_ready_l) begin
                cur_beats.push_back(s_data);
                if (cur_beats.size() == R || s_last) begin
                    word_t e;
                    e.d_l = '0; e.d_m = '0; e.k_l = '0; e.k_m = '0;
                    e.last = s_last;
                    for (int k = 0; k < cur_beats.size(); k++) begin
                        e.d_l = e.d_l | ((W*R)'(cur_beats[k]) << (k * W));
                        e.d_m = e.d_m | ((W*R)'(cur_beats[k]) << ((R - 1 - k) * W));
                        e.k_l[k] = 1'b1;
                        e.k_m[R-1-k] = 1'b1;
                    end
                    exp_q.push_back(e);
                    cur_beats.delete();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", 32'(m_valid_l), 32'd0);
        chk("rst_data", 32'(m_data_l), 32'd0);
        chk("rst_keep", 32'(m_keep_l), 32'd0);
        chk("rst_last", 32'(m_last_l), 32'd0);
        chk("rst_ready", 32'(s_ready_l), 32'd0);
        chk("rst_ready_msb", 32'(s_ready_m), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(s_ready_l), 32'd1);

        // Basic pair with last
        m_ready = 1'b1;
        beat(4'h3, 1'b0);
        chk("pair_mid_valid", 32'(m_valid_l), 32'd0);
        beat(4'h5, 1'b1);
        chk("pair_valid", 32'(m_valid_l), 32'd1);
        chk("pair_data_lsb", 32'(m_data_l), 32'h53);
        chk("pair_keep_lsb", 32'(m_keep_l), 32'h3);
        chk("pair_last", 32'(m_last_l), 32'd1);
        chk("pair_data_msb", 32'(m_data_m), 32'h35);
        chk("pair_keep_msb", 32'(m_keep_m), 32'h3);
        s_valid = 1'b0;
        tick();
        chk("pair_drained", 32'(m_valid_l), 32'd0);

        // Partial flush
        beat(4'h7, 1'b1);
        chk("part_valid", 32'(m_valid_l), 32'd1);
        chk("part_data_lsb", 32'(m_data_l), 32'h07);
        chk("part_keep_lsb", 32'(m_keep_l), 32'h1);
        chk("part_data_msb", 32'(m_data_m), 32'h70);
        chk("part_keep_msb", 32'(m_keep_m), 32'h2);
        chk("part_last", 32'(m_last_l), 32'd1);
        s_valid = 1'b0;
        tick();

        // Backpressure
        m_ready = 1'b0;
        beat(4'h1, 1'b0);
        beat(4'h2, 1'b0);
        chk("bp_valid", 32'(m_valid_l), 32'd1);
        chk("bp_data", 32'(m_data_l), 32'h21);
        chk("bp_last", 32'(m_last_l), 32'd0);
        s_valid = 1'b1;
        s_data  = 4'h4;
        s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_ready", 32'(s_ready_l), 32'd0);
            chk("bp_hold_data", 32'(m_data_l), 32'h21);
            chk("bp_hold_valid", 32'(m_valid_l), 32'd1);
            chk("bp_hold_keep", 32'(m_keep_l), 32'h3);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_ready_l), 32'd1);
        tick();
        chk("bp_taken", 32'(m_valid_l), 32'd0);
        beat(4'h8, 1'b0);
        chk("bp_next_valid", 32'(m_valid_l), 32'd1);
        chk("bp_next_data", 32'(m_data_l), 32'h84);
        chk("bp_next_data_msb", 32'(m_data_m), 32'h48);
        chk("bp_next_last", 32'(m_last_l), 32'd0);
        s_valid = 1'b0;
        tick();

        // Streaming
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 4'(i);
            s_last  = (i == 7);
            chk("str_ready", 32'(s_ready_l), 32'd1);
            tick();
            if (i % 2 == 1) begin
                chk("str_valid", 32'(m_valid_l), 32'd1);
                chk("str_data", 32'(m_data_l), 32'((i << 4) | (i - 1)));
                chk("str_keep", 32'(m_keep_l), 32'h3);
                chk("str_last", 32'(m_last_l), 32'(i == 7));
            end else begin
                chk("str_gap", 32'(m_valid_l), 32'd0);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();

        // Reset with a pending output word
        m_ready = 1'b0;
        beat(4'h9, 1'b0);
        beat(4'h6, 1'b0);
        s_valid = 1'b0;
        chk("rp_pending", 32'(m_data_l), 32'h69);
        #2;
        rst = 1'b1;
        #1;
        chk("rp_valid", 32'(m_valid_l), 32'd0);
        chk("rp_data", 32'(m_data_l), 32'd0);
        chk("rp_keep", 32'(m_keep_l), 32'd0);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        #1;

        // Reset with one accumulated beat
        beat(4'hA, 1'b0);
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rm_ready", 32'(s_ready_l), 32'd0);
        chk("rm_valid", 32'(m_valid_l), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rm_ready_back", 32'(s_ready_l), 32'd1);
        beat(4'hB, 1'b0);
        chk("rm_mid", 32'(m_valid_l), 32'd0);
        beat(4'hC, 1'b0);
        chk("rm_valid_word", 32'(m_valid_l), 32'd1);
        chk("rm_data", 32'(m_data_l), 32'hCB);
        chk("rm_data_msb", 32'(m_data_m), 32'hBC);
        chk("rm_keep", 32'(m_keep_l), 32'h3);
        s_valid = 1'b0;
        tick();
        chk("rm_drained", 32'(m_valid_l), 32'd0);

        // Random phase
        en_sb = 1'b1;
        for (int c = 0; c < 600; c++) begin
            s_valid = ($urandom_range(3) != 0);
            s_data  = 4'($urandom);
            s_last  = ($urandom_range(4) == 0);
            m_ready = ($urandom_range(3) != 0);
            tick();
        end
        s_valid = 1'b1;
        s_data  = 4'($urandom);
        s_last  = 1'b1;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        en_sb = 1'b0;
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        chk("sb_enough_words", 32'(n_words > 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
